// File: rtl/aclint_timer_if.sv
// Request/response bus between a peripheral-bus master and the aclint_timer block.
//
// Handshake: the master raises req_valid for exactly one cycle per access,
// together with req_addr/req_wdata/req_we/req_size. There is no backpressure.
// The slave raises req_ready for exactly one cycle, one cycle after the
// request. req_rdata and req_err are only meaningful while req_ready is high.
// A new request may be issued in the cycle right after the previous one.
interface aclint_timer_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_size;
    logic        req_ready;
    logic [63:0] req_rdata;
    logic        req_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size,
        input  req_ready, req_rdata, req_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size,
        output req_ready, req_rdata, req_err
    );
endinterface

// File: rtl/aclint_timer.sv
// aclint_timer: core-local timer and software-interrupt block for NUM_HARTS harts.
// Shared MTIME with a tick prescaler, per-hart MTIMECMP/MSIP, registered responses.
// Optional supervisor software interrupt (SETSSIP) is built when ACLINT_SSWI_EN is
// defined; otherwise the SETSSIP range decodes as unmapped and ssi_o is tied low.
module aclint_timer #(
    parameter int NUM_HARTS   = 1,
    parameter int MTIME_WIDTH = 64,
    parameter int TICK_DIV    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aclint_timer_if.slave        bus,
    output logic [NUM_HARTS-1:0] mti_o,
    output logic [NUM_HARTS-1:0] msi_o,
    output logic [NUM_HARTS-1:0] ssi_o
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME,
        REG_SSIP
    } reg_sel_e;

    logic [MTIME_WIDTH-1:0] mtime_q, mtime_d;
    logic [15:0]            presc_q, presc_d;
    logic [MTIME_WIDTH-1:0] mtimecmp_q [NUM_HARTS];
    logic [MTIME_WIDTH-1:0] mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0]   msip_q, msip_d;
    logic [NUM_HARTS-1:0]   mti_q, mti_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [63:0]            rdata_q, rdata_d;

    reg_sel_e    sel;
    logic [11:0] hart;
    logic [2:0]  off;
    logic [7:0]  be;
    logic [7:0]  lanes;
    logic        bad_size;
    logic        misalign;
    logic        acc_err;
    logic        wr_en;
    logic [63:0] rmask;
    logic [63:0] wmask;
    logic [63:0] wdata_sh;
    logic [63:0] reg_val;
    logic [63:0] rd_val;

    // Address decode: target register, hart index and byte offset inside the register.
    always_comb begin
        sel  = REG_NONE;
        hart = '0;
        off  = '0;
        if (bus.req_addr < 16'h4000) begin
            sel  = REG_MSIP;
            hart = bus.req_addr[13:2];
            off  = {1'b0, bus.req_addr[1:0]};
        end else if (bus.req_addr < 16'hBFF8) begin
            sel  = REG_MTIMECMP;
            hart = 12'(bus.req_addr[15:3] - 13'h0800);
            off  = bus.req_addr[2:0];
        end else if (bus.req_addr < 16'hC000) begin
            sel  = REG_MTIME;
            off  = bus.req_addr[2:0];
        end else begin
`ifdef ACLINT_SSWI_EN
            sel  = REG_SSIP;
            hart = bus.req_addr[13:2];
            off  = {1'b0, bus.req_addr[1:0]};
`endif
        end
    end

    // Access size, error conditions and byte-lane masks for the current request.
    always_comb begin
        bad_size = 1'b0;
        misalign = 1'b0;
        be       = 8'h00;
        case (bus.req_size)
            3'd0: be = 8'h01;
            3'd1: begin be = 8'h03; misalign = bus.req_addr[0];       end
            3'd2: begin be = 8'h0F; misalign = |bus.req_addr[1:0];    end
            3'd3: begin be = 8'hFF; misalign = |bus.req_addr[2:0];    end
            default: bad_size = 1'b1;
        endcase

        acc_err = bad_size | misalign | (sel == REG_NONE);
        // Hart-indexed registers beyond the implemented harts behave as unmapped.
        if ((sel == REG_MSIP || sel == REG_MTIMECMP || sel == REG_SSIP) &&
            ({20'b0, hart} >= 32'(NUM_HARTS)))
            acc_err = 1'b1;
        // MSIP and SETSSIP are 32-bit registers; doubleword access is illegal.
        if ((sel == REG_MSIP || sel == REG_SSIP) && bus.req_size == 3'd3)
            acc_err = 1'b1;

        wr_en    = bus.req_valid & bus.req_we & ~acc_err;
        lanes    = be << off;
        wdata_sh = bus.req_wdata << {off, 3'b000};
        for (int b = 0; b < 8; b++) begin
            rmask[b*8 +: 8] = {8{be[b]}};
            wmask[b*8 +: 8] = {8{lanes[b]}};
        end
    end

    // Read mux: select the register, shift the addressed lane down, clip to size.
    always_comb begin
        reg_val = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (hart == 12'(i)) begin
                if (sel == REG_MSIP)     reg_val = 64'(msip_q[i]);
                if (sel == REG_MTIMECMP) reg_val = 64'(mtimecmp_q[i]);
            end
        end
        if (sel == REG_MTIME) reg_val = 64'(mtime_q);
        rd_val = (reg_val >> {off, 3'b000}) & rmask;
    end

    // MTIME and prescaler: a write wins over the tick and restarts the prescaler.
    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        if (wr_en && sel == REG_MTIME) begin
            mtime_d = MTIME_WIDTH'((64'(mtime_q) & ~wmask) | (wdata_sh & wmask));
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            mtime_d = mtime_q + MTIME_WIDTH'(1);
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Per-hart compare registers, software-interrupt bits and timer compare.
    always_comb begin
        msip_d = msip_q;
        for (int i = 0; i < NUM_HARTS; i++) begin
            mtimecmp_d[i] = mtimecmp_q[i];
            mti_d[i]      = (mtime_q >= mtimecmp_q[i]);
            if (wr_en && hart == 12'(i)) begin
                if (sel == REG_MTIMECMP)
                    mtimecmp_d[i] = MTIME_WIDTH'((64'(mtimecmp_q[i]) & ~wmask) |
                                                 (wdata_sh & wmask));
                // Only bit 0 of MSIP is implemented; it changes only when lane 0 is written.
                if (sel == REG_MSIP && lanes[0])
                    msip_d[i] = wdata_sh[0];
            end
        end
    end

    // Response: one cycle after every request, data zeroed on writes and errors.
    always_comb begin
        ready_d = bus.req_valid;
        err_d   = bus.req_valid & acc_err;
        rdata_d = (bus.req_valid && !bus.req_we && !acc_err) ? rd_val : 64'd0;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q <= '0;
            presc_q <= '0;
            msip_q  <= '0;
            mti_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_HARTS; i++) mtimecmp_q[i] <= '1;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
            msip_q  <= msip_d;
            mti_q   <= mti_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < NUM_HARTS; i++) mtimecmp_q[i] <= mtimecmp_d[i];
        end
    end

`ifdef ACLINT_SSWI_EN
    logic [NUM_HARTS-1:0] ssi_q, ssi_d;

    // SETSSIP: writing 1 to bit 0 produces a one-cycle pulse; writing 0 does nothing.
    always_comb begin
        ssi_d = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (wr_en && sel == REG_SSIP && hart == 12'(i) && lanes[0] && wdata_sh[0])
                ssi_d[i] = 1'b1;
        end
    end

    // Pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ssi_q <= '0;
        else          ssi_q <= ssi_d;
    end

    assign ssi_o = ssi_q;
`else
    assign ssi_o = '0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign mti_o         = mti_q;
    assign msi_o         = msip_q;

endmodule

// File: tb/tb_aclint_timer.sv
// Testbench for aclint_timer. Two instances share one request stream:
// dut0 = 2 harts, 64-bit MTIME, TICK_DIV=4; dut1 = 1 hart, 32-bit MTIME, TICK_DIV=1.
// A register-level reference model predicts every response and interrupt line.
module tb_aclint_timer;

    localparam int NH0 = 2;
    localparam int W0  = 64;
    localparam int D0  = 4;
    localparam int NH1 = 1;
    localparam int W1  = 32;
    localparam int D1  = 1;
`ifdef ACLINT_SSWI_EN
    localparam bit SSWI = 1'b1;
`else
    localparam bit SSWI = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    aclint_timer_if bus0 ();
    aclint_timer_if bus1 ();

    logic [NH0-1:0] mti0, msi0, ssi0;
    logic [NH1-1:0] mti1, msi1, ssi1;

    aclint_timer #(.NUM_HARTS(NH0), .MTIME_WIDTH(W0), .TICK_DIV(D0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .mti_o   (mti0),
        .msi_o   (msi0),
        .ssi_o   (ssi0)
    );

    aclint_timer #(.NUM_HARTS(NH1), .MTIME_WIDTH(W1), .TICK_DIV(D1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .mti_o   (mti1),
        .msi_o   (msi1),
        .ssi_o   (ssi1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mtime [2];
    int          m_presc [2];
    logic [63:0] m_cmp   [2][2];
    logic [1:0]  m_msip  [2];
    logic        e_ready [2];
    logic        e_err   [2];
    logic [63:0] e_rdata [2];
    logic [1:0]  e_mti   [2];
    logic [1:0]  e_ssi   [2];

    function automatic int nh_of(input int k);
        return (k == 0) ? NH0 : NH1;
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic logic [63:0] wmask_of(input int k);
        int w;
        w = (k == 0) ? W0 : W1;
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mtime[k]  = '0;
            m_presc[k]  = 0;
            m_cmp[k][0] = wmask_of(k);
            m_cmp[k][1] = wmask_of(k);
            m_msip[k]   = '0;
            e_ready[k]  = 1'b0;
            e_err[k]    = 1'b0;
            e_rdata[k]  = '0;
            e_mti[k]    = '0;
            e_ssi[k]    = '0;
        end
    endtask

    // One clock edge of one instance: predict the response/lines, then advance state.
    task automatic model_step(input int k, input bit v, input int ai, input logic [63:0] wd,
                              input bit we, input int sz);
        int          region, h, roff, nb;
        bit          err, do_wr;
        logic [63:0] val, smask, pmask, nv;
        region = 0; h = 0; roff = 0; val = '0;
        if (ai < 'h4000) begin
            region = 1; h = ai / 4; roff = ai % 4;
        end else if (ai < 'hBFF8) begin
            region = 2; h = (ai - 'h4000) / 8; roff = ai % 8;
        end else if (ai < 'hC000) begin
            region = 3; roff = ai - 'hBFF8;
        end else if (SSWI) begin
            region = 4; h = (ai - 'hC000) / 4; roff = ai % 4;
        end
        nb  = (sz <= 3) ? (1 << sz) : 1;
        err = (region == 0) || (sz > 3) || (ai % nb != 0) ||
              ((region == 1 || region == 2 || region == 4) && h >= nh_of(k)) ||
              (sz == 3 && (region == 1 || region == 4));
        if (!err) begin
            case (region)
                1:       val = 64'(m_msip[k][h]);
                2:       val = m_cmp[k][h];
                3:       val = m_mtime[k];
                default: val = '0;
            endcase
        end
        smask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        pmask = smask << (8 * roff);
        nv    = (val & ~pmask) | ((wd & smask) << (8 * roff));
        if (region == 2 || region == 3) nv = nv & wmask_of(k);

        e_ready[k] = v;
        e_err[k]   = v && err;
        e_rdata[k] = (v && !we && !err) ? ((val >> (8 * roff)) & smask) : 64'd0;
        e_mti[k]   = '0;
        for (int j = 0; j < nh_of(k); j++) e_mti[k][j] = (m_mtime[k] >= m_cmp[k][j]);

        do_wr    = v && we && !err;
        e_ssi[k] = '0;
        if (do_wr && region == 4 && roff == 0 && wd[0]) e_ssi[k][h] = 1'b1;

        if (do_wr && region == 3) begin
            m_mtime[k] = nv;
            m_presc[k] = 0;
        end else begin
            m_presc[k]++;
            if (m_presc[k] == div_of(k)) begin
                m_presc[k] = 0;
                m_mtime[k] = (m_mtime[k] + 64'd1) & wmask_of(k);
            end
        end
        if (do_wr && region == 1) m_msip[k][h] = nv[0];
        if (do_wr && region == 2) m_cmp[k][h]  = nv;
    endtask

    task automatic cmp_one(input int k, input logic g_ready, input logic g_err,
                           input logic [63:0] g_rdata, input logic [63:0] g_mti,
                           input logic [63:0] g_msi, input logic [63:0] g_ssi);
        check($sformatf("d%0d_ready", k), 64'(g_ready), 64'(e_ready[k]));
        if (e_ready[k]) begin
            check($sformatf("d%0d_err", k), 64'(g_err), 64'(e_err[k]));
            check($sformatf("d%0d_rdata", k), g_rdata, e_rdata[k]);
        end
        check($sformatf("d%0d_mti", k), g_mti, 64'(e_mti[k]));
        check($sformatf("d%0d_msi", k), g_msi, 64'(m_msip[k]));
        check($sformatf("d%0d_ssi", k), g_ssi, 64'(e_ssi[k]));
    endtask

    task automatic compare_all();
        cmp_one(0, bus0.req_ready, bus0.req_err, bus0.req_rdata, 64'(mti0), 64'(msi0), 64'(ssi0));
        cmp_one(1, bus1.req_ready, bus1.req_err, bus1.req_rdata, 64'(mti1), 64'(msi1), 64'(ssi1));
    endtask

    // ---------------- driver ----------------
    task automatic set_req(input bit v, input logic [15:0] a, input logic [63:0] wd,
                           input bit we, input logic [2:0] sz);
        bus0.req_valid = v; bus0.req_addr = a; bus0.req_wdata = wd;
        bus0.req_we    = we; bus0.req_size = sz;
        bus1.req_valid = v; bus1.req_addr = a; bus1.req_wdata = wd;
        bus1.req_we    = we; bus1.req_size = sz;
    endtask

    task automatic cycle(input bit v, input logic [15:0] a, input logic [63:0] wd,
                         input bit we, input logic [2:0] sz);
        set_req(v, a, wd, we, sz);
        for (int k = 0; k < 2; k++) model_step(k, v, int'(a), wd, we, int'(sz));
        @(posedge clk);
        #1;
        compare_all();
        set_req(1'b0, 16'h0, 64'h0, 1'b0, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 64'h0, 1'b0, 3'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] wd;
        int          a, sz, cls;

        reset_n = 1'b0;
        set_req(1'b0, 16'h0, 64'h0, 1'b0, 3'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;

        // Free-running MTIME read at cycle 10, then a compare-register read.
        idle(9);
        cycle(1'b1, 16'hBFF8, 64'h0, 1'b0, 3'd3);
        cycle(1'b1, 16'h4004, 64'h0, 1'b0, 3'd2);

        // MTIME write restarts the prescaler.
        cycle(1'b1, 16'hBFF8, 64'h10, 1'b1, 3'd3);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'hBFF8, 64'h0, 1'b0, 3'd3);

        // Timer compare rises after MTIME reaches MTIMECMP, falls after max write.
        cycle(1'b1, 16'h4000, m_mtime[0] + 64'd20, 1'b1, 3'd3);
        idle(90);
        cycle(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3);
        idle(3);

        // Software interrupts: hart 1 exists only in dut0, hart 2 in neither.
        cycle(1'b1, 16'h0004, 64'h1, 1'b1, 3'd2);
        cycle(1'b1, 16'h0008, 64'h1, 1'b1, 3'd2);
        cycle(1'b1, 16'h0004, 64'h0, 1'b0, 3'd2);

        // MTIME wrap, upper word of a narrow timer, and D access to MSIP.
        cycle(1'b1, 16'hBFF8, 64'h1_FFFF_FFFE, 1'b1, 3'd3);
        cycle(1'b1, 16'hBFF8, 64'h0, 1'b0, 3'd3);
        idle(2);
        cycle(1'b1, 16'hBFFC, 64'h0, 1'b0, 3'd2);
        cycle(1'b1, 16'h0000, 64'h1, 1'b1, 3'd3);

        // SETSSIP pulse and misaligned access.
        cycle(1'b1, 16'hC000, 64'h1, 1'b1, 3'd2);
        cycle(1'b1, 16'hC000, 64'h0, 1'b0, 3'd2);
        cycle(1'b1, 16'h4001, 64'h0, 1'b0, 3'd1);
        idle(2);

        // Randomised traffic around every register region.
        for (int n = 0; n < 600; n++) begin
            cls = int'($urandom_range(0, 5));
            case (cls)
                0:       a = int'($urandom_range(0, 2)) * 4 + int'($urandom_range(0, 3));
                1:       a = 'h4000 + int'($urandom_range(0, 2)) * 8 + int'($urandom_range(0, 7));
                2:       a = 'hBFF8 + int'($urandom_range(0, 7));
                3:       a = 'hC000 + int'($urandom_range(0, 2)) * 4 + int'($urandom_range(0, 3));
                default: a = int'($urandom_range(0, 65535));
            endcase
            sz = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 7))
                                              : int'($urandom_range(0, 3));
            if (sz <= 3 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            case ($urandom_range(0, 2))
                0:       wd = m_mtime[0] + 64'($urandom_range(0, 30));
                1:       wd = 64'($urandom_range(0, 100));
                default: wd = {$urandom, $urandom};
            endcase
            cycle($urandom_range(0, 9) < 7, 16'(a), wd, 1'($urandom_range(0, 1)), 3'(sz));
        end

        // Reset asserted while a request is in flight: no response, write lost.
        set_req(1'b1, 16'h0000, 64'h1, 1'b1, 3'd2);
        #2;
        reset_n = 1'b0;
        set_req(1'b0, 16'h0, 64'h0, 1'b0, 3'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        cycle(1'b1, 16'hBFF8, 64'h0, 1'b0, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
